// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, byte_sel encodings, FSM states and store lane helpers
package mem_access_pkg;

   localparam int MEM_ADDR_WIDTH = 32;
   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int BYTE_SEL       = 3;
   localparam int SEL_UNSIGNED   = 2;

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

   localparam logic [1:0] SL_BYTE = 2'b00;
   localparam logic [1:0] SL_HALF = 2'b01;
   localparam logic [1:0] SL_WORD = 2'b10;
   localparam logic [1:0] SL_NONE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_GNT,
      ST_WAIT_DATA,
      ST_WB
   } state_t;

   // Natural alignment: halves on even bytes, words on multiples of four.
   function automatic logic addr_aligned(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SL_HALF: addr_aligned = ~lane[0];
         SL_WORD: addr_aligned = (lane == 2'b00);
         default: addr_aligned = 1'b1;
      endcase
   endfunction

   // Byte strobes for a store of the given size at the given byte lane.
   function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SL_BYTE: store_strb = 4'b0001 << lane;
         SL_HALF: store_strb = 4'b0011 << lane;
         default: store_strb = 4'b1111;
      endcase
   endfunction

   // Replicate the right-aligned store data across all lanes; strobes pick the live one.
   function automatic logic [DATA_WIDTH-1:0] store_data(input logic [1:0] size,
                                                        input logic [DATA_WIDTH-1:0] d);
      case (size)
         SL_BYTE: store_data = {4{d[7:0]}};
         SL_HALF: store_data = {2{d[15:0]}};
         default: store_data = d;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - word-aligned data bus with req/gnt/rvalid handshake
import mem_access_pkg::*;

interface mem_access_if;
   logic                      bus_req;
   logic                      bus_we;
   logic [MEM_ADDR_WIDTH-1:0] bus_addr;
   logic [3:0]                bus_wstrb;
   logic [DATA_WIDTH-1:0]     bus_wdata;
   logic                      bus_gnt;
   logic                      bus_rvalid;
   logic [DATA_WIDTH-1:0]     bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wstrb, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );
endinterface

// File: rtl/mem_access_load_extract.sv
// rtl/mem_access_load_extract.sv - load lane select with sign/zero extension
import mem_access_pkg::*;

module mem_access_load_extract (
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            lane,
   input  logic [1:0]            size,
   input  logic                  uns,
   output logic [DATA_WIDTH-1:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Pick the addressed byte/half out of the bus word and widen it to 32 bits.
   always_comb begin
      byte_v = rdata[{lane, 3'b000} +: 8];
      half_v = rdata[{lane[1], 4'b0000} +: 16];
      case (size)
         SL_BYTE: data = uns ? {24'h000000, byte_v} : {{24{byte_v[7]}}, byte_v};
         SL_HALF: data = uns ? {16'h0000, half_v}   : {{16{half_v[15]}}, half_v};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store stage: bus handshake, PC hold, load write-back
import mem_access_pkg::*;

module mem_access #(
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mem_re,
   input  logic                      mem_we,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_raddr,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_waddr,
   input  logic [DATA_WIDTH-1:0]     mem_wdata,
   input  logic [BYTE_SEL-1:0]       byte_sel,
   input  logic [REG_ADDR_WIDTH-1:0] rd_waddr,
   mem_access_if.master              bus,
   output logic                      rd_we_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_waddr_o,
   output logic [DATA_WIDTH-1:0]     rd_wdata_o,
   output logic                      hold_o,
   output logic                      err_o
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   state_t                      state;
   logic [1:0]                  lane_q;
   logic [1:0]                  size_q;
   logic                        uns_q;
   logic                        we_q;
   logic [REG_ADDR_WIDTH-1:0]   rd_q;
   logic [31:0]                 cnt;

   logic                        req_v;
   logic                        illegal;
   logic                        aligned;
   logic                        start;
   logic                        reject;
   logic [MEM_ADDR_WIDTH-1:0]   req_addr;
   logic [DATA_WIDTH-1:0]       ld_data;

   // Classify the request offered by execute while the stage is idle.
   always_comb begin
      illegal  = mem_re & mem_we;
      req_addr = mem_we ? mem_waddr : mem_raddr;
      req_v    = (mem_re ^ mem_we) && (byte_sel[1:0] != SL_NONE);
      aligned  = addr_aligned(byte_sel[1:0], req_addr[1:0]);
      start    = (state == ST_IDLE) && req_v && aligned;
      reject   = (state == ST_IDLE) && (illegal || (req_v && !aligned));
   end

   // PC stall covers the accept cycle and every cycle a transaction is on the bus.
   assign hold_o = rst && (start || (state == ST_WAIT_GNT) || (state == ST_WAIT_DATA));

   mem_access_load_extract u_load_extract (
      .rdata (bus.bus_rdata),
      .lane  (lane_q),
      .size  (size_q),
      .uns   (uns_q),
      .data  (ld_data)
   );

   // Access FSM with registered bus, write-back and error outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         lane_q        <= 2'b00;
         size_q        <= SL_BYTE;
         uns_q         <= 1'b0;
         we_q          <= 1'b0;
         rd_q          <= ZERO_REG;
         cnt           <= '0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wstrb <= 4'b0000;
         bus.bus_wdata <= '0;
         rd_we_o       <= 1'b0;
         rd_waddr_o    <= ZERO_REG;
         rd_wdata_o    <= '0;
         err_o         <= 1'b0;
      end else begin
         err_o   <= 1'b0;
         rd_we_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               cnt <= '0;
               if (start) begin
                  lane_q        <= req_addr[1:0];
                  size_q        <= byte_sel[1:0];
                  uns_q         <= byte_sel[SEL_UNSIGNED];
                  we_q          <= mem_we;
                  rd_q          <= rd_waddr;
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= mem_we;
                  bus.bus_addr  <= {req_addr[MEM_ADDR_WIDTH-1:2], 2'b00};
                  bus.bus_wstrb <= mem_we ? store_strb(byte_sel[1:0], req_addr[1:0]) : 4'b0000;
                  bus.bus_wdata <= mem_we ? store_data(byte_sel[1:0], mem_wdata) : '0;
                  state         <= ST_WAIT_GNT;
               end else if (reject) begin
                  err_o <= 1'b1;
               end
            end
            ST_WAIT_GNT: begin
               if (bus.bus_gnt) begin
                  bus.bus_req <= 1'b0;
                  cnt         <= '0;
                  state       <= we_q ? ST_IDLE : ST_WAIT_DATA;
               end else if (cnt == TO_LAST) begin
                  bus.bus_req <= 1'b0;
                  err_o       <= 1'b1;
                  cnt         <= '0;
                  state       <= ST_IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_WAIT_DATA: begin
               if (bus.bus_rvalid) begin
                  rd_wdata_o <= ld_data;
                  rd_waddr_o <= rd_q;
                  rd_we_o    <= (rd_q != ZERO_REG);
                  cnt        <= '0;
                  state      <= ST_WB;
               end else if (cnt == TO_LAST) begin
                  err_o <= 1'b1;
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            ST_WB: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
